execute_issue_ctrl: RTL and testbench

EXECUTE_ISSUE_CTRL -- requirements
Module: execute_issue_ctrl

---
 rtl/execute_issue_ctrl.sv | 157 +++++++++++++++
 tb/tb_execute_issue_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_issue_ctrl.sv
// execute_issue_ctrl: accepts a vector command, streams cmd_len operand chunks
// into the execute unit with one registered cycle of latency, then spends one
// drain cycle before reporting done.
// Build option: define ISSUE_STALL_CNT_EN to add the stall_cnt output, which
// counts ISSUE cycles where the operand source stalled.
module execute_issue_ctrl #(
  parameter int PE_COUNT     = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int LEN_WIDTH    = 8,
  parameter int OP_SEL_WIDTH = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cmd_valid,
  output logic                                      cmd_ready,
  input  logic [OP_SEL_WIDTH-1:0]                   cmd_op,
  input  logic                                      cmd_dot,
  input  logic [LEN_WIDTH-1:0]                      cmd_len,
  input  logic                                      opnd_valid,
  output logic                                      opnd_ready,
  input  logic signed [PE_COUNT-1:0][DATA_WIDTH-1:0] opnd_a,
  input  logic signed [PE_COUNT-1:0][DATA_WIDTH-1:0] opnd_b,
  output logic signed [PE_COUNT-1:0][DATA_WIDTH-1:0] a,
  output logic signed [PE_COUNT-1:0][DATA_WIDTH-1:0] b,
  output logic [OP_SEL_WIDTH-1:0]                   pe_op,
  output logic                                      dot_prod_en,
  output logic                                      shift,
  output logic                                      issue_valid,
  output logic                                      busy,
`ifdef ISSUE_STALL_CNT_EN
  output logic [15:0]                               stall_cnt,
`endif
  output logic                                      done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Dot products always run the PEs in multiply mode.
  localparam logic [OP_SEL_WIDTH-1:0] OP_MUL = '1;

  state_t                                      state_q;
  logic [LEN_WIDTH-1:0]                        remain_q;
  logic                                        first_q;
  logic                                        dot_q;
  logic                                        dot_en_q;
  logic                                        shift_q;
  logic                                        issue_valid_q;
  logic [OP_SEL_WIDTH-1:0]                     pe_op_q;
  logic signed [PE_COUNT-1:0][DATA_WIDTH-1:0]  a_q;
  logic signed [PE_COUNT-1:0][DATA_WIDTH-1:0]  b_q;

  logic accept;
  logic chunk_pending;
  logic xfer;

  // ISSUE with remain_q==0 is the cycle where the last chunk sits on a/b;
  // the source is no longer asked for data then.
  assign accept        = (state_q == S_IDLE) && cmd_valid;
  assign chunk_pending = (state_q == S_ISSUE) && (remain_q != '0);
  assign xfer          = chunk_pending && opnd_valid;

  // Command FSM together with the registered operand/control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      remain_q      <= '0;
      first_q       <= 1'b0;
      dot_q         <= 1'b0;
      dot_en_q      <= 1'b0;
      shift_q       <= 1'b0;
      issue_valid_q <= 1'b0;
      pe_op_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
    end else begin
      issue_valid_q <= 1'b0;
      shift_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            dot_q    <= cmd_dot;
            pe_op_q  <= cmd_dot ? OP_MUL : cmd_op;
            remain_q <= cmd_len;
            first_q  <= 1'b1;
            state_q  <= (cmd_len != '0) ? S_ISSUE : S_DRAIN;
          end
        end
        S_ISSUE: begin
          if (remain_q == '0) begin
            state_q <= S_DRAIN;
          end else if (opnd_valid) begin
            a_q           <= opnd_a;
            b_q           <= opnd_b;
            issue_valid_q <= 1'b1;
            shift_q       <= dot_q && first_q;
            first_q       <= 1'b0;
            remain_q      <= remain_q - LEN_WIDTH'(1);
            if (dot_q) begin
              dot_en_q <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          state_q  <= S_IDLE;
          dot_en_q <= 1'b0;
          dot_q    <= 1'b0;
          pe_op_q  <= '0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  // Saturating count of cycles the operand source left us waiting.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      stall_cnt_d = '0;
    end else if (chunk_pending && !opnd_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign cmd_ready   = (state_q == S_IDLE);
  assign opnd_ready  = chunk_pending;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DRAIN);
  assign a           = a_q;
  assign b           = b_q;
  assign pe_op       = pe_op_q;
  assign dot_prod_en = dot_en_q;
  assign shift       = shift_q;
  assign issue_valid = issue_valid_q;

endmodule

// File: tb/tb_execute_issue_ctrl.sv
// Bench for execute_issue_ctrl: a per-cycle behavioural model built on chunk
// counts, a table of directed vectors, hand-written corner sequences and a
// randomized run.
module tb_execute_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_dot;
  logic [7:0]  cmd_len;
  logic        opnd_valid;
  logic        opnd_ready;
  logic [3:0][7:0] opnd_a;
  logic [3:0][7:0] opnd_b;
  logic [3:0][7:0] a;
  logic [3:0][7:0] b;
  logic [1:0]  pe_op;
  logic        dot_prod_en;
  logic        shift;
  logic        issue_valid;
  logic        busy;
  logic        done;
`ifdef ISSUE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  execute_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dot(cmd_dot), .cmd_len(cmd_len),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
    .opnd_a(opnd_a), .opnd_b(opnd_b),
    .a(a), .b(b), .pe_op(pe_op),
    .dot_prod_en(dot_prod_en), .shift(shift),
    .issue_valid(issue_valid), .busy(busy),
`ifdef ISSUE_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- comparison helpers ----------------
  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A command is "active" from the cycle after accept until done. While
  // chunks remain the source is asked for data; once all are sent there is
  // one cycle showing the last chunk, then the done cycle.
  bit          m_active;
  bit          m_drain;
  bit          m_prev;
  bit          m_dot;
  logic [1:0]  m_op;
  int          m_len;
  int          m_sent;
  int          m_stall;
  logic [31:0] m_a;
  logic [31:0] m_b;

  task automatic model_reset();
    m_active = 0; m_drain = 0; m_prev = 0; m_dot = 0; m_op = 2'd0;
    m_len = 0; m_sent = 0; m_stall = 0; m_a = 32'h0; m_b = 32'h0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else if (!m_active) begin
      m_prev = 0;
      if (cmd_valid) begin
        m_active = 1; m_dot = cmd_dot; m_op = cmd_op;
        m_len = int'(cmd_len); m_sent = 0; m_stall = 0;
        m_drain = (m_len == 0);
        $display("cmd t=%0t op=%0d dot=%0d len=%0d", $time, cmd_op, cmd_dot, cmd_len);
      end
    end else if (m_drain) begin
      m_active = 0; m_drain = 0; m_prev = 0;
    end else if (m_sent < m_len) begin
      m_prev = opnd_valid;
      if (opnd_valid) begin
        m_sent++; m_a = opnd_a; m_b = opnd_b;
      end else if (m_stall < 65535) begin
        m_stall++;
      end
    end else begin
      m_drain = 1; m_prev = 0;
    end
  endtask

  task automatic check_model();
    chk1("cmd_ready", cmd_ready, !m_active);
    chk1("opnd_ready", opnd_ready, m_active && !m_drain && (m_sent < m_len));
    chk1("busy", busy, m_active);
    chk1("done", done, m_drain);
    chk1("issue_valid", issue_valid, m_prev);
    chk1("shift", shift, m_prev && m_dot && (m_sent == 1));
    chk1("dot_prod_en", dot_prod_en, m_active && m_dot && (m_sent >= 1));
    chk32("a", a, m_a);
    chk32("b", b, m_b);
    if (m_active) chk2("pe_op", pe_op, m_dot ? 2'b11 : m_op);
`ifdef ISSUE_STALL_CNT_EN
    chk32("stall_cnt", {16'h0, stall_cnt}, 32'(m_stall));
`endif
  endtask

  // Check this cycle, advance the model, then move to just after next edge.
  task automatic cyc();
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic cv, input logic [1:0] op, input logic dt, input logic [7:0] ln,
                     input logic ov, input logic [31:0] oa, input logic [31:0] ob);
    cmd_valid = cv; cmd_op = op; cmd_dot = dt; cmd_len = ln;
    opnd_valid = ov; opnd_a = oa; opnd_b = ob;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        cv;
    logic [1:0]  op;
    logic        dot;
    logic [7:0]  len;
    logic        ov;
    logic [31:0] oa;
    logic [31:0] ob;
    logic        e_crdy;
    logic        e_ordy;
    logic        e_busy;
    logic        e_iv;
    logic        e_done;
    logic [1:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n_dot, n_shift, n_mul, shift_at, last_iv, done_at, seen_done, n_acc, n_x, n_iv;
    bit got;

    // len=1 pass-B command, then a len=0 command.
    tbl[0] = '{1'b1, 2'd0, 1'b0, 8'd1, 1'b0, 32'h0, 32'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 32'h01020304, 32'h10203040,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0,
               1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h01020304, 32'h10203040};
    tbl[3] = '{1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h01020304, 32'h10203040};
    tbl[4] = '{1'b1, 2'd2, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h01020304, 32'h10203040};
    tbl[5] = '{1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 32'h01020304, 32'h10203040};
    tbl[6] = '{1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h01020304, 32'h10203040};

    // Reset with a command pending: reset must win.
    rst = 1'b1;
    drv(1'b1, 2'd3, 1'b1, 8'd5, 1'b1, 32'hDEADBEEF, 32'hCAFEF00D);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_issue_valid", issue_valid, 1'b0);
    chk1("rst_shift", shift, 1'b0);
    chk1("rst_dot_prod_en", dot_prod_en, 1'b0);
    chk2("rst_pe_op", pe_op, 2'd0);
    chk32("rst_a", a, 32'h0);
    chk32("rst_b", b, 32'h0);
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_opnd_ready", opnd_ready, 1'b0);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      drv(tbl[i].cv, tbl[i].op, tbl[i].dot, tbl[i].len, tbl[i].ov, tbl[i].oa, tbl[i].ob);
      chk1("tbl_cmd_ready", cmd_ready, tbl[i].e_crdy);
      chk1("tbl_opnd_ready", opnd_ready, tbl[i].e_ordy);
      chk1("tbl_busy", busy, tbl[i].e_busy);
      chk1("tbl_issue_valid", issue_valid, tbl[i].e_iv);
      chk1("tbl_done", done, tbl[i].e_done);
      if (tbl[i].e_busy) chk2("tbl_pe_op", pe_op, tbl[i].e_op);
      chk32("tbl_a", a, tbl[i].e_a);
      chk32("tbl_b", b, tbl[i].e_b);
      cyc();
    end

    // Dot command, len=4, four back-to-back all-one chunks.
    n_dot = 0; n_shift = 0; n_mul = 0; shift_at = -1; last_iv = -1; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      if (dot_prod_en) n_dot++;
      if (shift) begin n_shift++; shift_at = i; end
      if (issue_valid) last_iv = i;
      if (done) done_at = i;
      if (busy && pe_op == 2'b11) n_mul++;
      if (i == 0) drv(1'b1, 2'd1, 1'b1, 8'd4, 1'b0, 32'h0, 32'h0);
      else if (i <= 4) drv(1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 32'h01010101, 32'h01010101);
      else drv(1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0);
      cyc();
    end
    chkn("dot_en_cycles", n_dot, 5);
    chkn("shift_cycles", n_shift, 1);
    chkn("shift_at", shift_at, 2);
    chkn("dot_done_after_last_issue", done_at - last_iv, 1);
    chkn("dot_pe_op_mul_cycles", n_mul, 6);

    // len=3 with a two-cycle source stall after chunk 1.
    for (int i = 0; i < 12; i++) begin
      if (i == 3 || i == 4) begin
        chk1("stall_issue_valid", issue_valid, 1'b0);
        chk32("stall_hold_a", a, 32'h11121314);
        chk32("stall_hold_b", b, 32'h21222324);
      end
      case (i)
        0: drv(1'b1, 2'd1, 1'b0, 8'd3, 1'b0, 32'h0, 32'h0);
        1: drv(1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 32'h11121314, 32'h21222324);
        4: drv(1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 32'h31323334, 32'h41424344);
        5: drv(1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 32'h51525354, 32'h61626364);
        default: drv(1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0);
      endcase
      cyc();
    end
`ifdef ISSUE_STALL_CNT_EN
    chk32("stall_cnt_two", {16'h0, stall_cnt}, 32'd2);
`endif

    // Reset in the middle of a len=4 dot command, with handshakes asserted.
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen_done++;
      if (i == 4) begin
        chk32("abort_a", a, 32'h0);
        chk32("abort_b", b, 32'h0);
        chk2("abort_pe_op", pe_op, 2'd0);
        chk1("abort_dot_prod_en", dot_prod_en, 1'b0);
        chk1("abort_shift", shift, 1'b0);
        chk1("abort_issue_valid", issue_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
      end
      rst = (i == 3);
      case (i)
        0: drv(1'b1, 2'd0, 1'b1, 8'd4, 1'b0, 32'h0, 32'h0);
        1: drv(1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 32'h0A0B0C0D, 32'h01020304);
        2: drv(1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 32'h0E0F1011, 32'h05060708);
        3: drv(1'b1, 2'd2, 1'b0, 8'd2, 1'b1, 32'h7F7F7F7F, 32'h80808080);
        default: drv(1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0);
      endcase
      cyc();
    end
    rst = 1'b0;
    chkn("abort_no_done", seen_done, 0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen_done++;
      if (i == 0) drv(1'b1, 2'd3, 1'b0, 8'd1, 1'b0, 32'h0, 32'h0);
      else if (i == 1) drv(1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 32'hF0E0D0C0, 32'h0F0E0D0C);
      else drv(1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0);
      cyc();
    end
    chkn("after_abort_done", seen_done, 1);

    // cmd_valid held high across a busy command: one accept per IDLE visit.
    n_acc = 0;
    for (int i = 0; i < 18; i++) begin
      drv(i < 10, 2'd2, 1'b0, 8'd2, 1'b1, $urandom, $urandom);
      if (cmd_valid && cmd_ready) n_acc++;
      cyc();
    end
    chkn("held_cmd_accepts", n_acc, 2);

    // Maximum length command with a random source.
    drv(1'b1, 2'd1, 1'b0, 8'hFF, 1'b0, 32'h0, 32'h0);
    cyc();
    n_x = 0; n_iv = 0; got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      drv(1'b0, 2'd0, 1'b0, 8'd0, ($urandom % 4) != 0, $urandom, $urandom);
      if (opnd_valid && opnd_ready) n_x++;
      if (issue_valid) n_iv++;
      if (done) got = 1;
      cyc();
    end
    chk1("maxlen_done_seen", got, 1'b1);
    chkn("maxlen_transfers", n_x, 255);
    chkn("maxlen_issues", n_iv, 255);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = (($urandom % 200) == 0);
      drv(($urandom % 3) == 0, 2'($urandom), 1'($urandom),
          (($urandom % 4) == 0) ? 8'd0 : 8'($urandom_range(1, 6)),
          ($urandom % 3) != 0, $urandom, $urandom);
      cyc();
    end
    rst = 1'b0;
    drv(1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 32'h0, 32'h0);
    repeat (12) cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
